// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial adder sequencer.
//   - state_e   : sequencer state encoding (2'd3 is unused and recovers to IDLE)
//   - WIDTH_MAX : largest supported operand width
package serial_add_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if
//   Request/result bundle between an operand requester (master) and the
//   bit-serial adder sequencer (slave).
//   master drives : start, abort, a, b, cin
//   slave drives  : busy, done, sum, cout, ovf
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/full_adder.sv
// full_adder
//   Single 1-bit full adder cell, purely combinational.
//   Ports: a, b, cin -> sum, cout
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer: adds two WIDTH-bit operands one bit per clock
//   through one shared full_adder cell and a carry flip-flop.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - slave side of serial_add_ctrl_if
//             (start/abort/a/b/cin in; busy/done/sum/cout/ovf out)
//   Timing: start accepted at edge E0, WIDTH shift edges E1..EWIDTH, done high
//   for one cycle after EWIDTH, back to IDLE on the following edge.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_ctrl_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_CIN = CNT_W'(WIDTH - 2);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_sr_q;
    logic             carry_q;
    logic             msb_cin_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_sr_d;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // start wins over a simultaneous abort here
                    if (bus.start) begin
                        a_sr_q  <= bus.a;
                        b_sr_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // abort outranks the last-bit transition; results untouched
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        a_sr_q   <= a_sr_q >> 1;
                        b_sr_q   <= b_sr_q >> 1;
                        sum_sr_q <= sum_sr_d;
                        carry_q  <= fa_cout;
                        cnt_q    <= cnt_q + 1'b1;
                        // carry leaving bit WIDTH-2 is the carry into the MSB
                        if (cnt_q == CNT_MSB_CIN) begin
                            msb_cin_q <= fa_cout;
                        end
                        if (cnt_q == CNT_LAST) begin
                            sum_q   <= sum_sr_d;
                            cout_q  <= fa_cout;
                            ovf_q   <= msb_cin_q ^ fa_cout;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule
